// File: rtl/chip8_reg_xfer_pkg.sv
// Shared types and sizing constants for the CHIP-8 register bulk-transfer sequencer.
package chip8_pkg;

  localparam int CHIP8_ADDR_W = 12;
  localparam int CHIP8_DATA_W = 8;
  localparam int CHIP8_NREGS  = 16;

  typedef enum logic [1:0] {
    IDLE,
    STORE,
    LOAD,
    DONE
  } xfer_state_t;

endpackage

// File: rtl/chip8_reg_xfer_if.sv
// Decoder handshake, register-file port and RAM port of the FX55/FX65 sequencer.
// master = the sequencer; slave = decoder/register-file/RAM side.
interface chip8_reg_xfer_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
);

  logic              start;
  logic              dir;
  logic [3:0]        last_reg;
  logic [ADDR_W-1:0] base_addr;
  logic              busy;
  logic              done;
  logic [3:0]        rf_addr;
  logic [DATA_W-1:0] rf_rdata;
  logic [DATA_W-1:0] rf_wdata;
  logic              rf_wren;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_wren;
  logic              mem_rden;
  logic [DATA_W-1:0] mem_rdata;
  logic [ADDR_W-1:0] i_next;
  logic              i_wr;

  modport master (
    input  start, dir, last_reg, base_addr, rf_rdata, mem_rdata,
    output busy, done, rf_addr, rf_wdata, rf_wren,
           mem_addr, mem_wdata, mem_wren, mem_rden, i_next, i_wr
  );

  modport slave (
    output start, dir, last_reg, base_addr, rf_rdata, mem_rdata,
    input  busy, done, rf_addr, rf_wdata, rf_wren,
           mem_addr, mem_wdata, mem_wren, mem_rden, i_next, i_wr
  );

endinterface

// File: rtl/chip8_reg_xfer.sv
// FX55/FX65 sequencer: one register per cycle; store X+1 cycles, load X+2 (read then drain), then a done cycle.
// start is ignored while busy. Build option CHIP8_I_INCREMENT_EN writes I = base+X+1 in the done cycle.
module chip8_reg_xfer
  import chip8_pkg::*;
#(
  parameter int ADDR_W = CHIP8_ADDR_W,
  parameter int DATA_W = CHIP8_DATA_W
) (
  input  logic            clk,
  input  logic            rst,
  chip8_reg_xfer_if.master bus
);

  xfer_state_t       state_q, state_d;
  logic [4:0]        idx_q, idx_d;
  logic [3:0]        last_q, last_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              wr_vld_q, wr_vld_d;
  logic [3:0]        widx_q, widx_d;

  logic [ADDR_W-1:0] addr_sum;
  logic              issue;
  logic [DATA_W-1:0] rd_dat;

  assign addr_sum = base_q + ADDR_W'(idx_q);
  // idx is one bit wider than a register index so X=15 can reach the drain test
  assign issue    = (idx_q <= {1'b0, last_q});
  assign rd_dat   = bus.mem_rdata;
  assign bus.busy = (state_q != IDLE);

`ifdef CHIP8_I_INCREMENT_EN
  assign bus.i_next = (state_q == DONE) ? (base_q + ADDR_W'(last_q) + ADDR_W'(1)) : '0;
`else
  assign bus.i_next = base_q;
`endif

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    last_d        = last_q;
    base_d        = base_q;
    wr_vld_d      = 1'b0;
    widx_d        = widx_q;
    bus.done      = 1'b0;
    bus.rf_addr   = '0;
    bus.rf_wdata  = '0;
    bus.rf_wren   = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wren  = 1'b0;
    bus.mem_rden  = 1'b0;
    bus.i_wr      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          last_d  = bus.last_reg;
          base_d  = bus.base_addr;
          idx_d   = '0;
          state_d = bus.dir ? LOAD : STORE;
        end
      end

      STORE: begin
        bus.rf_addr   = idx_q[3:0];
        bus.mem_addr  = addr_sum;
        bus.mem_wdata = bus.rf_rdata;
        bus.mem_wren  = 1'b1;
        idx_d         = idx_q + 5'd1;
        if (idx_q == {1'b0, last_q}) begin
          state_d = DONE;
        end
      end

      LOAD: begin
        if (issue) begin
          bus.mem_rden = 1'b1;
          bus.mem_addr = addr_sum;
          idx_d        = idx_q + 5'd1;
          wr_vld_d     = 1'b1;
          widx_d       = idx_q[3:0];
        end else begin
          state_d = DONE;
        end
        // write stage consumes the read issued on the previous cycle
        if (wr_vld_q) begin
          bus.rf_wren  = 1'b1;
          bus.rf_addr  = widx_q;
          bus.rf_wdata = rd_dat;
        end
      end

      DONE: begin
        bus.done = 1'b1;
`ifdef CHIP8_I_INCREMENT_EN
        bus.i_wr = 1'b1;
`endif
        state_d  = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      last_q   <= '0;
      base_q   <= '0;
      wr_vld_q <= 1'b0;
      widx_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      last_q   <= last_d;
      base_q   <= base_d;
      wr_vld_q <= wr_vld_d;
      widx_q   <= widx_d;
    end
  end

endmodule

// File: tb/tb_chip8_reg_xfer.sv
// Bench for chip8_reg_xfer: behavioural register file and RAM, reference model of transfers.
module tb_chip8_reg_xfer;

  localparam int AW = 12;
  localparam int DW = 8;
  localparam int MSZ = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  chip8_reg_xfer_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  chip8_reg_xfer #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] rf_mem  [16];
  logic [7:0] ram     [MSZ];
  logic [7:0] ref_rf  [16];
  logic [7:0] ref_ram [MSZ];
  logic [7:0] mem_rdata_r;

  assign bus.rf_rdata  = rf_mem[bus.rf_addr];
  assign bus.mem_rdata = mem_rdata_r;

  int n_chk  = 0;
  int n_pass = 0;

  // snapshot of DUT outputs for the cycle most recently stepped through
  int s_busy, s_done, s_rf_addr, s_rf_wdata, s_rf_wren;
  int s_mem_addr, s_mem_wdata, s_mem_wren, s_mem_rden, s_i_next, s_i_wr;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  // Settle, snapshot outputs, take the clock edge, then apply the memory-model effects.
  task automatic step();
    #3;
    s_busy      = int'(bus.busy);
    s_done      = int'(bus.done);
    s_rf_addr   = int'(bus.rf_addr);
    s_rf_wdata  = int'(bus.rf_wdata);
    s_rf_wren   = int'(bus.rf_wren);
    s_mem_addr  = int'(bus.mem_addr);
    s_mem_wdata = int'(bus.mem_wdata);
    s_mem_wren  = int'(bus.mem_wren);
    s_mem_rden  = int'(bus.mem_rden);
    s_i_next    = int'(bus.i_next);
    s_i_wr      = int'(bus.i_wr);
    @(posedge clk);
    if (s_rf_wren == 1)  rf_mem[s_rf_addr % 16] = 8'(s_rf_wdata);
    if (s_mem_wren == 1) ram[s_mem_addr % MSZ]  = 8'(s_mem_wdata);
    if (s_mem_rden == 1) mem_rdata_r            = ram[s_mem_addr % MSZ];
    #1;
  endtask

  task automatic set_rf(input int i, input int v);
    rf_mem[i] = 8'(v);
    ref_rf[i] = 8'(v);
  endtask

  task automatic set_ram(input int a, input int v);
    ram[a % MSZ]     = 8'(v);
    ref_ram[a % MSZ] = 8'(v);
  endtask

  // One transfer: d=0 store, d=1 load; inj pulses a conflicting start while busy.
  task automatic run_xfer(input int d, input int x, input int b, input bit inj);
    int  exp_done, n_mw, n_rd, n_rw, iwr_cnt, done_at, a;
    bit  fin;
    exp_done = (d == 1) ? x + 3 : x + 2;
    n_mw = 0; n_rd = 0; n_rw = 0; iwr_cnt = 0; done_at = -1; fin = 1'b0;

    bus.start     = 1'b1;
    bus.dir       = d[0];
    bus.last_reg  = x[3:0];
    bus.base_addr = b[AW-1:0];
    step();
    chk("idle_before_start", s_busy, 0);
    bus.start = 1'b0;
    if (inj) begin
      bus.dir       = ~d[0];
      bus.last_reg  = 4'($urandom);
      bus.base_addr = AW'($urandom);
    end

    for (int cyc = 1; cyc <= 60 && !fin; cyc++) begin
      bus.start = (inj && cyc == 2);
      step();
      if (s_mem_wren == 1 && s_mem_rden == 1) chk("wren_rden_excl", 1, 0);
      if (s_i_wr == 1) iwr_cnt++;
      if (s_mem_wren == 1) begin
        chk("st_addr", s_mem_addr, (b + n_mw) % MSZ);
        chk("st_data", s_mem_wdata, int'(ref_rf[n_mw % 16]));
        chk("st_cycle", cyc, n_mw + 1);
        n_mw++;
      end
      if (s_mem_rden == 1) begin
        chk("ld_raddr", s_mem_addr, (b + n_rd) % MSZ);
        chk("ld_rcycle", cyc, n_rd + 1);
        n_rd++;
      end
      if (s_rf_wren == 1) begin
        chk("ld_rf_addr", s_rf_addr, n_rw);
        chk("ld_rf_data", s_rf_wdata, int'(ref_ram[(b + n_rw) % MSZ]));
        chk("ld_wcycle", cyc, n_rw + 2);
        n_rw++;
      end
      if (s_done == 1) begin
        chk("busy_in_done", s_busy, 1);
`ifdef CHIP8_I_INCREMENT_EN
        chk("i_wr_in_done", s_i_wr, 1);
        chk("i_next_in_done", s_i_next, (b + x + 1) % MSZ);
`else
        chk("i_next_modern", s_i_next, b);
`endif
        done_at = cyc;
        fin = 1'b1;
      end
    end
    bus.start = 1'b0;

    chk("done_cycle", done_at, exp_done);
`ifdef CHIP8_I_INCREMENT_EN
    chk("i_wr_count", iwr_cnt, 1);
`else
    chk("i_wr_count", iwr_cnt, 0);
`endif
    if (d == 1) begin
      chk("ld_n_reads", n_rd, x + 1);
      chk("ld_n_rfwr", n_rw, x + 1);
      chk("ld_n_memwr", n_mw, 0);
      for (int i = 0; i <= x; i++) ref_rf[i] = ref_ram[(b + i) % MSZ];
    end else begin
      chk("st_n_memwr", n_mw, x + 1);
      chk("st_n_reads", n_rd, 0);
      chk("st_n_rfwr", n_rw, 0);
      for (int i = 0; i <= x; i++) ref_ram[(b + i) % MSZ] = ref_rf[i];
    end

    for (int i = 0; i < 16; i++) chk("rf_contents", int'(rf_mem[i]), int'(ref_rf[i]));
    for (int i = 0; i <= x; i++) begin
      a = (b + i) % MSZ;
      chk("ram_contents", int'(ram[a]), int'(ref_ram[a]));
    end
  endtask

  initial begin
    int dn;
    bus.start     = 1'b0;
    bus.dir       = 1'b0;
    bus.last_reg  = '0;
    bus.base_addr = '0;
    mem_rdata_r   = '0;
    for (int i = 0; i < 16; i++)  set_rf(i, int'($urandom_range(0, 255)));
    for (int i = 0; i < MSZ; i++) set_ram(i, int'($urandom_range(0, 255)));

    rst = 1'b1;
    step();
    step();
    chk("rst_busy", s_busy, 0);
    chk("rst_done", s_done, 0);
    chk("rst_strobes", s_rf_wren + s_mem_wren + s_mem_rden + s_i_wr, 0);
    chk("rst_rf_addr", s_rf_addr, 0);
    chk("rst_rf_wdata", s_rf_wdata, 0);
    chk("rst_mem_addr", s_mem_addr, 0);
    chk("rst_mem_wdata", s_mem_wdata, 0);
    chk("rst_i_next", s_i_next, 0);
    rst = 1'b0;
    step();

    // store V0..V3 to 0x300
    set_rf(0, 11); set_rf(1, 22); set_rf(2, 33); set_rf(3, 44);
    run_xfer(0, 3, 'h300, 1'b0);

    // load V0..VF from 0x200.., issued back-to-back after the previous done
    for (int i = 0; i < 16; i++) set_ram('h200 + i, 'hA0 + i);
    run_xfer(1, 15, 'h200, 1'b0);

    // wrap at top of memory, then the minimal load
    run_xfer(0, 3, 'hFFE, 1'b0);
    run_xfer(1, 0, 'hFFF, 1'b0);

    // conflicting start while busy, both directions
    run_xfer(0, 5, 'h123, 1'b1);
    run_xfer(1, 7, 'hFFA, 1'b1);
    run_xfer(0, 15, 'h400, 1'b0);
    run_xfer(0, 0, 'h000, 1'b1);

    // reset after two load issues: only V0 lands, no done
    bus.start     = 1'b1;
    bus.dir       = 1'b1;
    bus.last_reg  = 4'd5;
    bus.base_addr = AW'('h500);
    step();
    bus.start = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    ref_rf[0] = ref_ram['h500];
    step();
    chk("rst_mid_busy", s_busy, 0);
    chk("rst_mid_strobes", s_rf_wren + s_mem_wren + s_mem_rden + s_i_wr, 0);
    dn = s_done;
    for (int i = 0; i < 4; i++) begin
      step();
      dn += s_done;
    end
    chk("rst_mid_no_done", dn, 0);
    for (int i = 0; i < 16; i++) chk("rst_mid_rf", int'(rf_mem[i]), int'(ref_rf[i]));

    // randomized transfers
    for (int t = 0; t < 30; t++) begin
      run_xfer(int'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
               int'($urandom_range(0, MSZ - 1)), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/chip8_reg_xfer.md
Name: chip8_reg_xfer

Overview:
Bulk transfer sequencer for CHIP-8 FX55 (store V0..VX to memory at I) and FX65 (load V0..VX from memory at I). It is the memory-facing master that drives the register file's read and write ports, one register per cycle. It sits between the instruction decoder (start/done handshake), the V-register file and the 4 KiB main RAM.

Parameters:
ADDR_W, 12, memory address width (4 KiB space); all address arithmetic is modulo 2^ADDR_W
DATA_W, 8, register and memory data width

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
start  in  1  pulse: begin transfer; sampled only when busy=0
dir  in  1  0 = store regs to mem (FX55), 1 = load mem to regs (FX65)
last_reg  in  4  X: highest register index transferred (inclusive)
base_addr  in  ADDR_W  current I value
busy  out  1  transfer in progress
done  out  1  one-cycle completion pulse
rf_addr  out  4  register file index
rf_rdata  in  DATA_W  register file combinational read data for rf_addr
rf_wdata  out  DATA_W  register write data
rf_wren  out  1  register write strobe
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_wren  out  1  RAM write strobe
mem_rden  out  1  RAM read strobe; mem_rdata valid exactly 1 cycle later
mem_rdata  in  DATA_W  RAM read data
i_next  out  ADDR_W  updated I value (see Optional Feature)
i_wr  out  1  I write strobe (see Optional Feature)

Behaviour:
- Interface decided: one clock; reset synchronous, active-high.
- Reset: state=IDLE. busy, done, rf_wren, mem_wren, mem_rden and i_wr are 0. rf_addr, rf_wdata, mem_addr, mem_wdata and i_next are 0.
- States: IDLE, STORE, LOAD, DONE.
- IDLE: when start=1 on edge E0, capture dir, last_reg and base_addr; clear idx=0. Go to STORE (dir=0) or LOAD (dir=1). Later input changes are ignored until return to IDLE.
- busy=1 in every non-IDLE state. start is ignored while busy=1.
- STORE, one register per cycle:
  - rf_addr=idx; mem_addr=base+idx (wraps mod 2^ADDR_W); mem_wdata=rf_rdata; mem_wren=1.
  - idx increments each cycle; after idx==last_reg go to DONE.
  - Cycle count: X+1 write cycles, then DONE.
- LOAD, two-stage pipeline:
  - Issue stage: mem_rden=1, mem_addr=base+idx, for idx 0..X in consecutive cycles.
  - Write stage, one cycle later: rf_wren=1, rf_addr=idx_d (registered issue index), rf_wdata=mem_rdata.
  - After the last issue, one drain cycle writes VX with mem_rden=0, then go to DONE.
  - Cycle count: X+2 busy cycles before DONE.
- DONE: done=1 for exactly one cycle, busy=1; next state IDLE. The next start is accepted the cycle after DONE.
- Strobes are never asserted outside these rules. mem_wren and mem_rden are never both high.
- last_reg=0: one write cycle (store) or one read plus one drain cycle (load).
- last_reg=15: full 16-register transfer. idx is 5 bits internally; no 4-bit overflow.
- Address wrap: base=0xFFE, X=3 → addresses 0xFFE, 0xFFF, 0x000, 0x001.
- Reset mid-operation: immediately IDLE, all strobes 0. Completed writes are not rolled back; no done pulse.

Optional Feature:
CHIP8_I_INCREMENT_EN
- Defined (COSMAC behaviour): in DONE, i_wr=1 and i_next=base+X+1 mod 2^ADDR_W.
- Undefined (modern behaviour): i_wr held 0; i_next=base (captured value) constantly after the first start.

Decomposition:
- Package chip8_pkg: state enum xfer_state_t {IDLE, STORE, LOAD, DONE}; constants CHIP8_ADDR_W=12, CHIP8_DATA_W=8, CHIP8_NREGS=16.
- No sub-module: the address adder and index counter are inline. The register file and RAM are external; the bench supplies behavioural models.

Test Plan:
- Store: V0..V3={11,22,33,44}, base=0x300, X=3, dir=0 → mem_wren for 4 consecutive cycles at 0x300..0x303 with data 11,22,33,44; done pulse 5 cycles after start.
- Load: RAM 0x200..0x20F = 0xA0..0xAF, X=15, dir=1 → rf_wren 16 cycles writing V0..VF=0xA0..0xAF; done 18 cycles after start; no mem_wren.
- Wrap and minimal case: base=0xFFE, X=3 store → addresses 0xFFE, 0xFFF, 0x000, 0x001. Then X=0 load → exactly one mem_rden and one rf_wren.
- Start while busy: assert start mid-transfer with different dir and X → ignored; original transfer completes unchanged; back-to-back start one cycle after done is accepted.
- Reset mid-load after 2 issues → next cycle busy=0 and all strobes 0; only V0 written; no done.
- Feature: with CHIP8_I_INCREMENT_EN, base=0x300, X=3 → i_wr pulse coincident with done, i_next=0x304. Without the macro → i_wr never asserted.
